button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 114 +++++++++++
 tb/tb_button_conditioner.sv | 133 +++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Button conditioner: per-button 2-flop sync + debounce, rising-edge pulses
// with reset > skip > start priority, and a long-press detector on reset.
`timescale 1ns/1ps

// One button lane: synchronizer followed by a mismatch-run debounce counter.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 400000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Sync raw input, then accept a new level after DEBOUNCE_CYCLES unbroken mismatches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 400000,
  parameter int LONG_CYCLES     = 80000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_skip,
  input  logic       btn_reset,
  output logic       start_pulse,
  output logic       skip_pulse,
  output logic       reset_pulse,
  output logic       long_reset_pulse,
  output logic [2:0] btn_level
);
  localparam int NUM_BTN = 3;
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] deb;
  logic [NUM_BTN-1:0] rise;
  logic [HW-1:0]      hold;

  assign raw = {btn_reset, btn_skip, btn_start};

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw[g]),
        .level(deb[g])
      );
    end
  endgenerate

  // deb leads btn_level by one cycle, so this marks the cycle a level rises.
  assign rise = deb & ~btn_level;

  // Register levels and prioritised press pulses; lower-priority coincident presses are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_level   <= '0;
      reset_pulse <= 1'b0;
      skip_pulse  <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      btn_level   <= deb;
      reset_pulse <= rise[2];
      skip_pulse  <= rise[1] & ~rise[2];
      start_pulse <= rise[0] & ~rise[1] & ~rise[2];
    end
  end

  // Long-press: count from the cycle after btn_level[2] rises, saturate, clear as the level falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold             <= '0;
      long_reset_pulse <= 1'b0;
    end else begin
      long_reset_pulse <= 1'b0;
      if (!deb[2]) begin
        hold <= '0;
      end else if (btn_level[2] && hold != HOLD_MAX) begin
        hold             <= hold + 1'b1;
        long_reset_pulse <= (hold == HOLD_LAST);
      end
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed, table-driven bench for button_conditioner (DEBOUNCE=4, LONG=16).
// Each table row: inputs applied before edge E0+k, expected outputs after edge E0+k.
`timescale 1ns/1ps

module tb_button_conditioner;
  logic       clk, rst;
  logic       btn_start, btn_skip, btn_reset;
  logic       start_pulse, skip_pulse, reset_pulse, long_reset_pulse;
  logic [2:0] btn_level;

  int n_cmp  = 0;
  int n_fail = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_start       (btn_start),
    .btn_skip        (btn_skip),
    .btn_reset       (btn_reset),
    .start_pulse     (start_pulse),
    .skip_pulse      (skip_pulse),
    .reset_pulse     (reset_pulse),
    .long_reset_pulse(long_reset_pulse),
    .btn_level       (btn_level)
  );

  initial clk = 1'b0;
  always #12.5 clk = ~clk;

  // pls = {long, reset, skip, start}; btn = {reset, skip, start}
  typedef struct {
    int         sid;
    int         k;
    logic       rst_n;
    logic [2:0] btn;
    logic [2:0] lvl;
    logic [3:0] pls;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int sid, int k, logic rn, logic [2:0] b,
                              logic [2:0] l, logic [3:0] p);
    vec_t v;
    v.sid = sid; v.k = k; v.rst_n = rn; v.btn = b; v.lvl = l; v.pls = p;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int sid, input int k,
                       input logic [2:0] el, input logic [3:0] ep);
    logic [3:0] gp;
    gp = {long_reset_pulse, reset_pulse, skip_pulse, start_pulse};
    n_cmp++;
    if (btn_level !== el || gp !== ep) begin
      n_fail++;
      $display("FAIL %s seq%0d k=%0d: got lvl=%b pls=%b, want lvl=%b pls=%b",
               name, sid, k, btn_level, gp, el, ep);
    end
  endtask

  initial begin
    rst = 1'b0;
    {btn_reset, btn_skip, btn_start} = 3'b111;

    // Reset state: everything 0 even with all buttons pressed.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_state", 0, i, 3'b000, 4'b0000);
    end
    {btn_reset, btn_skip, btn_start} = 3'b000;
    rst = 1'b1;

    // 1: 20-cycle start press; level 6..25, pulse at 6 only.
    for (int k = 0; k < 32; k++)
      add(1, k, 1'b1, (k < 20) ? 3'b001 : 3'b000,
          (k >= 6 && k < 26) ? 3'b001 : 3'b000, (k == 6) ? 4'b0001 : 4'b0000);
    // 2: 2-cycle glitch -> nothing.
    for (int k = 0; k < 12; k++)
      add(2, k, 1'b1, (k < 2) ? 3'b001 : 3'b000, 3'b000, 4'b0000);
    // 3: 3-cycle glitch (one short of DEBOUNCE) -> nothing.
    for (int k = 0; k < 12; k++)
      add(3, k, 1'b1, (k < 3) ? 3'b001 : 3'b000, 3'b000, 4'b0000);
    // 4: minimum 4-cycle press -> level 6..9, pulse at 6.
    for (int k = 0; k < 14; k++)
      add(4, k, 1'b1, (k < 4) ? 3'b001 : 3'b000,
          (k >= 6 && k < 10) ? 3'b001 : 3'b000, (k == 6) ? 4'b0001 : 4'b0000);
    // 5: 3 high, 1 low, 3 high -> counter restarts, nothing.
    for (int k = 0; k < 14; k++)
      add(5, k, 1'b1, (k < 3 || (k >= 4 && k < 7)) ? 3'b001 : 3'b000, 3'b000, 4'b0000);
    // 6: skip+reset together held 12 -> reset pulse only, level 110 for 6..17.
    for (int k = 0; k < 22; k++)
      add(6, k, 1'b1, (k < 12) ? 3'b110 : 3'b000,
          (k >= 6 && k < 18) ? 3'b110 : 3'b000, (k == 6) ? 4'b0100 : 4'b0000);
    // 7: skip+start together -> skip pulse, start dropped.
    for (int k = 0; k < 18; k++)
      add(7, k, 1'b1, (k < 10) ? 3'b011 : 3'b000,
          (k >= 6 && k < 16) ? 3'b011 : 3'b000, (k == 6) ? 4'b0010 : 4'b0000);
    // 8: reset held 30 -> pulse at 6, long at 22 only, level 6..35.
    for (int k = 0; k < 40; k++)
      add(8, k, 1'b1, (k < 30) ? 3'b100 : 3'b000,
          (k >= 6 && k < 36) ? 3'b100 : 3'b000,
          (k == 6) ? 4'b0100 : (k == 22) ? 4'b1000 : 4'b0000);
    // 9: reset held 10 -> pulse once, no long.
    for (int k = 0; k < 20; k++)
      add(9, k, 1'b1, (k < 10) ? 3'b100 : 3'b000,
          (k >= 6 && k < 16) ? 3'b100 : 3'b000, (k == 6) ? 4'b0100 : 4'b0000);
    // 10: skip held, rst low at 4,5 -> press discarded, pulse 6 edges after release (12).
    for (int k = 0; k < 16; k++)
      add(10, k, !(k == 4 || k == 5), 3'b010,
          (k >= 12) ? 3'b010 : 3'b000, (k == 12) ? 4'b0010 : 4'b0000);
    // 11: reset held, rst low at 10,11 mid-hold -> new press at 18, long at 34 not 22.
    for (int k = 0; k < 40; k++)
      add(11, k, !(k == 10 || k == 11), (k < 36) ? 3'b100 : 3'b000,
          ((k >= 6 && k < 10) || k >= 18) ? 3'b100 : 3'b000,
          (k == 6 || k == 18) ? 4'b0100 : (k == 34) ? 4'b1000 : 4'b0000);

    foreach (tbl[i]) begin
      if (tbl[i].k == 0) begin
        rst = 1'b1;
        {btn_reset, btn_skip, btn_start} = 3'b000;
        repeat (12) @(negedge clk);
      end
      rst = tbl[i].rst_n;
      {btn_reset, btn_skip, btn_start} = tbl[i].btn;
      @(posedge clk);
      @(negedge clk);
      check("vec", tbl[i].sid, tbl[i].k, tbl[i].lvl, tbl[i].pls);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
